// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
//
// Two-requester arbiter/sequencer in front of a single MMIO device port.
// Requester 0 is the core data-memory stage and requester 1 is the
// debug/loader path. It accepts one request at a time with round-robin
// fairness. Each request drives exactly one device access cycle. For a
// read it waits RD_LATENCY cycles. It then returns a one-cycle response.
// Only one transaction is outstanding at any time.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mN_req_valid/ready         request handshake (ready is combinational, IDLE only)
//   mN_req_addr/wen/wdata/wstrb  request payload, N in {0,1}
//   mN_resp_valid/rdata        one-cycle response pulse; rdata is 0 for writes
//   dev_addr/ren/wen/wdata/wstrb  device access, active only in ISSUE
//   dev_rdata                  device read data, sampled RD_LATENCY cycles after dev_ren

module mmio_bus_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wstrb,
    output logic                m0_resp_valid,
    output logic [DATA_W-1:0]   m0_resp_rdata,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wstrb,
    output logic                m1_resp_valid,
    output logic [DATA_W-1:0]   m1_resp_rdata,

    output logic [ADDR_W-1:0]   dev_addr,
    output logic                dev_ren,
    output logic                dev_wen,
    output logic [DATA_W-1:0]   dev_wdata,
    output logic [DATA_W/8-1:0] dev_wstrb,
    input  logic [DATA_W-1:0]   dev_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 4;  // holds RD_LATENCY up to 15

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_next;
    logic                rr_ptr;      // preferred requester when both are valid
    logic                gnt_id;      // requester owning the current transaction
    logic                gnt_sel;     // requester chosen this cycle in IDLE
    logic                handshake;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_wen;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_wstrb;
    logic [DATA_W-1:0]   rdata_q;

    // Grant selection: a lone valid requester always wins. On contention the
    // round-robin pointer decides.
    always_comb begin
        if (m0_req_valid && m1_req_valid) gnt_sel = rr_ptr;
        else                              gnt_sel = m1_req_valid;
    end

    // Ready is gated by rst_n, so no requester sees ready while reset is held.
    assign handshake    = rst_n && (state == IDLE) && (m0_req_valid || m1_req_valid);
    assign m0_req_ready = handshake && !gnt_sel;
    assign m1_req_ready = handshake &&  gnt_sel;

    // Next-state logic and the device/response outputs decoded from the state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_next    = state;
        dev_addr      = '0;
        dev_ren       = 1'b0;
        dev_wen       = 1'b0;
        dev_wdata     = '0;
        dev_wstrb     = '0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_resp_rdata = '0;
        m1_resp_rdata = '0;

        case (state)
            IDLE: begin
                if (handshake) state_next = ISSUE;
            end
            ISSUE: begin
                dev_addr   = lat_addr;
                dev_wdata  = lat_wdata;
                dev_wstrb  = lat_wstrb;
                dev_wen    = lat_wen;
                dev_ren    = !lat_wen;
                state_next = lat_wen ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) state_next = RESP;
            end
            RESP: begin
                if (gnt_id) begin
                    m1_resp_valid = 1'b1;
                    m1_resp_rdata = lat_wen ? '0 : rdata_q;
                end else begin
                    m0_resp_valid = 1'b1;
                    m0_resp_rdata = lat_wen ? '0 : rdata_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, request latch, latency counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the latch and capture registers are reset as well as the
        // control state, so an aborted transaction leaves nothing behind.
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gnt_id    <= 1'b0;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before this edge regardless of statement order.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        gnt_id    <= gnt_sel;
                        lat_addr  <= gnt_sel ? m1_req_addr  : m0_req_addr;
                        lat_wen   <= gnt_sel ? m1_req_wen   : m0_req_wen;
                        lat_wdata <= gnt_sel ? m1_req_wdata : m0_req_wdata;
                        lat_wstrb <= gnt_sel ? m1_req_wstrb : m0_req_wstrb;
                    end
                end
                ISSUE: begin
                    if (!lat_wen) cnt <= CNT_W'(RD_LATENCY);
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) rdata_q <= dev_rdata;
                end
                RESP: begin
                    rr_ptr <= !gnt_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter.
// dut_a (RD_LATENCY=1) runs a per-cycle vector table. It also runs a
// reset-abort sequence and a round-robin stress run.
// dut_b (RD_LATENCY=3) covers the longer read latency and a reset during WAIT.

module tb_mmio_bus_arbiter;

    typedef struct packed {
        logic        v0, w0;
        logic [31:0] a0, wd0;
        logic [3:0]  s0;
        logic        v1, w1;
        logic [31:0] a1, wd1;
        logic [3:0]  s1;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        r0, r1, v0, v1;
        logic [31:0] d0, d1;
        logic [31:0] addr;
        logic        ren, wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    localparam int OW = $bits(out_t);

    logic clk = 1'b0;
    logic rst_n;
    in_t  a_in, b_in;
    out_t a_out, b_out;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // dut_a outputs
    logic        a_r0, a_r1, a_v0, a_v1, a_ren, a_wen;
    logic [31:0] a_d0, a_d1, a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    // dut_b outputs
    logic        b_r0, b_r1, b_v0, b_v1, b_ren, b_wen;
    logic [31:0] b_d0, b_d1, b_addr, b_wdata;
    logic [3:0]  b_wstrb;

    assign a_out = {a_r0, a_r1, a_v0, a_v1, a_d0, a_d1, a_addr, a_ren, a_wen, a_wdata, a_wstrb};
    assign b_out = {b_r0, b_r1, b_v0, b_v1, b_d0, b_d1, b_addr, b_ren, b_wen, b_wdata, b_wstrb};

    mmio_bus_arbiter #(.RD_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(a_in.v0), .m0_req_ready(a_r0), .m0_req_addr(a_in.a0),
        .m0_req_wen(a_in.w0), .m0_req_wdata(a_in.wd0), .m0_req_wstrb(a_in.s0),
        .m0_resp_valid(a_v0), .m0_resp_rdata(a_d0),
        .m1_req_valid(a_in.v1), .m1_req_ready(a_r1), .m1_req_addr(a_in.a1),
        .m1_req_wen(a_in.w1), .m1_req_wdata(a_in.wd1), .m1_req_wstrb(a_in.s1),
        .m1_resp_valid(a_v1), .m1_resp_rdata(a_d1),
        .dev_addr(a_addr), .dev_ren(a_ren), .dev_wen(a_wen),
        .dev_wdata(a_wdata), .dev_wstrb(a_wstrb), .dev_rdata(a_in.rdata)
    );

    mmio_bus_arbiter #(.RD_LATENCY(3), .ADDR_W(32), .DATA_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(b_in.v0), .m0_req_ready(b_r0), .m0_req_addr(b_in.a0),
        .m0_req_wen(b_in.w0), .m0_req_wdata(b_in.wd0), .m0_req_wstrb(b_in.s0),
        .m0_resp_valid(b_v0), .m0_resp_rdata(b_d0),
        .m1_req_valid(b_in.v1), .m1_req_ready(b_r1), .m1_req_addr(b_in.a1),
        .m1_req_wen(b_in.w1), .m1_req_wdata(b_in.wd1), .m1_req_wstrb(b_in.s1),
        .m1_resp_valid(b_v1), .m1_resp_rdata(b_d1),
        .dev_addr(b_addr), .dev_ren(b_ren), .dev_wen(b_wen),
        .dev_wdata(b_wdata), .dev_wstrb(b_wstrb), .dev_rdata(b_in.rdata)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t in_m0(input logic v, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] s);
        in_t r = '0;
        r.v0 = v; r.w0 = w; r.a0 = a; r.wd0 = d; r.s0 = s;
        return r;
    endfunction

    function automatic in_t in_m1(input logic v, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] s);
        in_t r = '0;
        r.v1 = v; r.w1 = w; r.a1 = a; r.wd1 = d; r.s1 = s;
        return r;
    endfunction

    function automatic in_t in_rd(input logic [31:0] d);
        in_t r = '0;
        r.rdata = d;
        return r;
    endfunction

    function automatic out_t o_rdy(input logic r0, input logic r1);
        out_t o = '0;
        o.r0 = r0; o.r1 = r1;
        return o;
    endfunction

    function automatic out_t o_dev(input logic [31:0] addr, input logic ren, input logic wen,
                                   input logic [31:0] wd, input logic [3:0] st);
        out_t o = '0;
        o.addr = addr; o.ren = ren; o.wen = wen; o.wdata = wd; o.wstrb = st;
        return o;
    endfunction

    function automatic out_t o_resp(input logic v0, input logic [31:0] d0,
                                    input logic v1, input logic [31:0] d1);
        out_t o = '0;
        o.v0 = v0; o.d0 = d0; o.v1 = v1; o.d1 = d1;
        return o;
    endfunction

    task automatic push(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n; v.stim = i; v.exp = o;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_t both_w;
        int  resp_cnt, overlap_cnt, late_resp;

        rst_n = 1'b0;
        a_in  = '0;
        b_in  = '0;
        a_in.v0 = 1'b1;  // ready must stay low while reset is held
        a_in.v1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", a_out, '0);
        check("reset_b", b_out, '0);

        // m0 write to the UART
        push("w0_hs",    in_m0(1, 1, 32'h1000_03f8, 32'h48, 4'hF), o_rdy(1, 0));
        push("w0_issue", '0, o_dev(32'h1000_03f8, 0, 1, 32'h48, 4'hF));
        push("w0_resp",  '0, o_resp(1, 0, 0, 0));
        push("w0_idle",  '0, '0);
        // m1 read, RD_LATENCY=1; data present during cycle 2 only
        push("r1_hs",    in_m1(1, 0, 32'h10, 0, 0), o_rdy(0, 1));
        push("r1_issue", '0, o_dev(32'h10, 1, 0, 0, 0));
        push("r1_wait",  in_rd(32'hDEAD_BEEF), '0);
        push("r1_resp",  in_rd(32'h1234_5678), o_resp(0, 0, 1, 32'hDEAD_BEEF));
        push("r1_idle",  '0, '0);
        // zero-strobe write is still issued and acknowledged with rdata 0
        push("ws0_hs",    in_m0(1, 1, 32'h3f8, 32'h55, 4'h0), o_rdy(1, 0));
        push("ws0_issue", '0, o_dev(32'h3f8, 0, 1, 32'h55, 4'h0));
        push("ws0_resp",  '0, o_resp(1, 0, 0, 0));
        push("ws0_idle",  '0, '0);
        // contention after an m0 grant: m1 wins, m0 waits, then m0 is served
        both_w = in_t'(in_m0(1, 1, 32'h20, 32'h11, 4'h3) | in_m1(1, 1, 32'h30, 32'h22, 4'hC));
        push("both_hs",     both_w, o_rdy(0, 1));
        push("both_issue1", in_m0(1, 1, 32'h20, 32'h11, 4'h3), o_dev(32'h30, 0, 1, 32'h22, 4'hC));
        push("both_resp1",  in_m0(1, 1, 32'h20, 32'h11, 4'h3), o_resp(0, 0, 1, 0));
        push("both_hs0",    in_m0(1, 1, 32'h20, 32'h11, 4'h3), o_rdy(1, 0));
        push("both_issue0", '0, o_dev(32'h20, 0, 1, 32'h11, 4'h3));
        push("both_resp0",  '0, o_resp(1, 0, 0, 0));
        push("both_idle",   '0, '0);

        @(negedge clk);
        rst_n = 1'b1;
        a_in  = '0;
        foreach (vecs[i]) begin
            a_in = vecs[i].stim;
            #1;
            check(vecs[i].name, a_out, vecs[i].exp);
            @(negedge clk);
        end

        // Abort an m0 read while the strobe is high. The RR pointer is 1 here
        // and must come back as 0.
        a_in = in_m0(1, 0, 32'h40, 0, 0);
        #1;
        check("abort_hs", OW'(a_out.r0), 1);
        @(negedge clk);
        a_in = '0;
        #1;
        check("abort_issue_ren", OW'(a_out.ren), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_async_zero", a_out, '0);
        a_in = in_t'(in_m0(1, 1, 32'h100, 32'hA0, 4'hF) | in_m1(1, 1, 32'h200, 32'hB0, 4'hF));
        #1;
        check("reset_ready_gated", a_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesters always valid: 8 writes alternate m0,m1,... over 24 cycles.
        resp_cnt    = 0;
        overlap_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            logic [4:0] exp_bits;
            int         phase, who;
            phase = c % 3;
            who   = (c / 3) % 2;
            exp_bits = {(phase == 0) && (who == 0), (phase == 0) && (who == 1),
                        (phase == 2) && (who == 0), (phase == 2) && (who == 1),
                        (phase == 1)};
            #1;
            check($sformatf("rr_cycle%0d", c), OW'({a_out.r0, a_out.r1, a_out.v0, a_out.v1, a_out.wen}),
                  OW'(exp_bits));
            if (a_out.ren && a_out.wen) overlap_cnt++;
            if (a_out.v0 || a_out.v1) resp_cnt++;
            @(negedge clk);
        end
        a_in = '0;
        check("rr_resp_count", OW'(resp_cnt), 8);
        check("rr_no_strobe_overlap", OW'(overlap_cnt), 0);

        // RD_LATENCY=3 read; device data changes every cycle, cycle-4 value returned.
        for (int c = 0; c < 7; c++) begin
            out_t e;
            b_in = (c == 0) ? in_m0(1, 0, 32'h44, 0, 0) : in_t'('0);
            b_in.rdata = 32'hA000_0000 + 32'(c);
            case (c)
                0:       e = o_rdy(1, 0);
                1:       e = o_dev(32'h44, 1, 0, 0, 0);
                5:       e = o_resp(1, 32'hA000_0004, 0, 0);
                default: e = '0;
            endcase
            #1;
            check($sformatf("lat3_cycle%0d", c), b_out, e);
            @(negedge clk);
        end

        // Reset pulsed while dut_b is in WAIT: no response may follow.
        b_in = in_m0(1, 0, 32'h48, 0, 0);
        b_in.rdata = 32'h5555_5555;
        #1;
        check("b_abort_hs", OW'(b_out.r0), 1);
        @(negedge clk);
        b_in = in_rd(32'h5555_5555);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("b_wait_reset_zero", b_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        late_resp = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (b_out.v0 || b_out.v1 || b_out.ren) late_resp++;
            @(negedge clk);
        end
        check("b_no_resp_after_abort", OW'(late_resp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
Two-requester arbiter/sequencer in front of the single simulation MMIO device port (addr/ren/rdata/wdata/wen/wstrb, UART at low half 0x03f8). Requester 0 is the core data-memory stage and requester 1 is the debug/loader path. The arbiter accepts one request at a time with round-robin fairness, drives exactly one device access cycle, waits the device read latency and returns a single-cycle response. Only one transaction is outstanding at any time.

Parameters:
RD_LATENCY, 1, cycles from dev_ren assertion to the cycle dev_rdata is sampled; legal range 1..15
ADDR_W, 32, address width
DATA_W, 32, data width (dev_wstrb width = DATA_W/8)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
mN_req_valid  input  1  request valid, N in {0,1}
mN_req_ready  output  1  request accepted this cycle (handshake = valid & ready)
mN_req_addr  input  ADDR_W  request address
mN_req_wen  input  1  1 = write, 0 = read
mN_req_wdata  input  DATA_W  write data
mN_req_wstrb  input  DATA_W/8  byte strobes, writes only
mN_resp_valid  output  1  one-cycle response pulse; no backpressure
mN_resp_rdata  output  DATA_W  read data; 0 for write responses
dev_addr  output  ADDR_W  device address
dev_ren  output  1  device read strobe
dev_wen  output  1  device write strobe
dev_wdata  output  DATA_W  device write data
dev_wstrb  output  DATA_W/8  device byte strobes
dev_rdata  input  DATA_W  device read data

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. While it is low: all outputs are 0, state = IDLE, RR pointer = 0 (m0 has priority), wait counter = 0, latched request cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - mN_req_ready is combinational: asserted only for the grantee, and only in IDLE.
  - Grantee when only one valid: that requester. When both valid: the requester the RR pointer selects.
  - On handshake: latch addr/wen/wdata/wstrb and grantee id, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (exactly 1 cycle): dev_addr/dev_wdata/dev_wstrb driven from the latch.
  - Write: dev_wen=1, dev_ren=0, next state RESP.
  - Read: dev_ren=1, dev_wen=0, load counter with RD_LATENCY, next state WAIT.
- WAIT: decrement counter each cycle. On the cycle counter==1, capture dev_rdata and go to RESP.
- RESP (1 cycle):
  - Grantee's mN_resp_valid=1; mN_resp_rdata = captured data (read) or 0 (write).
  - The other requester's resp_valid stays 0.
  - RR pointer moves to the non-grantee. Next state IDLE.
- dev_ren and dev_wen are never high together and are high only in ISSUE. dev_addr/dev_wdata/dev_wstrb are 0 outside ISSUE.
- Latency from handshake cycle (cycle 0):
  - Write: ISSUE at cycle 1, resp_valid at cycle 2.
  - Read: ISSUE at cycle 1, sample at cycle 1+RD_LATENCY, resp_valid at cycle 2+RD_LATENCY.
  - The next handshake occurs no earlier than the cycle after RESP.
- Request inputs are ignored outside IDLE. A requester holds valid and payload stable until ready is seen.
- A write with wstrb=0 is still issued (dev_wen=1, dev_wstrb=0) and acknowledged.
- Reset asserted mid-transaction aborts it: no response is produced, any pending dev strobe drops immediately, and the RR pointer returns to 0.
- rst_n deasserted with both requesters valid: m0 wins the first grant.

Test Plan:
- m0 write addr 0x1000_03f8, wdata 0x48, wstrb 0xF -> m0_req_ready cycle 0; dev_wen=1 with those values cycle 1 only; m0_resp_valid=1, rdata=0 at cycle 2; m1 outputs stay 0.
- m1 read 0x0000_0010, RD_LATENCY=1, dev_rdata=0xDEAD_BEEF during cycle 2 -> dev_ren cycle 1; m1_resp_valid at cycle 3 with 0xDEAD_BEEF.
- Both requesters hold valid continuously, 4 writes each -> grants alternate m0,m1,m0,m1…; 8 responses over 24 cycles; dev_ren and dev_wen are never high together.
- RD_LATENCY=3 read with dev_rdata changing every cycle -> value present at cycle 4 is returned; resp_valid at cycle 5.
- rst_n pulsed low during WAIT -> outputs go 0 asynchronously; no resp_valid; after release with both valid, m0 is granted first.
- Write with wstrb=0x0 to 0x03f8 -> dev_wen=1, dev_wstrb=0 for one cycle; response still returned at cycle 2.
